// File: rtl/dec3to8_seq.sv
// Buffered 3-to-8 decoder: accepted codes queue in a small FIFO and each is
// presented as a one-hot value on o for HOLD_CYCLES clock cycles.
module dec3to8_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  input  logic       flush,
  output logic [7:0] o,
  output logic       o_valid,
  output logic       done,
  output logic [7:0] count,
  output logic       busy
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW:0] DEPTH_W  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      r_state;
  logic [7:0]  r_hold_cnt;
  logic [7:0]  r_o;
  logic [7:0]  r_count;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [2:0]  r_mem [FIFO_DEPTH];

  logic        w_empty;
  logic        w_full;
  logic        w_last;
  logic        w_push;
  logic        w_pop;
  logic [2:0]  w_head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = ((r_wr_ptr - r_rd_ptr) == DEPTH_W);
  assign w_last  = (r_state == HOLD) && (r_hold_cnt == 8'd0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = !w_empty && ((r_state == IDLE) || w_last);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign in_ready = !w_full;
  assign o        = r_o;
  assign o_valid  = (r_state == HOLD);
  assign done     = w_last;
  assign count    = r_count;
  assign busy     = (r_state == HOLD) || !w_empty;

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= in_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hold_cnt <= 8'd0;
      r_o        <= 8'd0;
      r_count    <= 8'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (flush) begin
      r_state    <= IDLE;
      r_hold_cnt <= 8'd0;
      r_o        <= 8'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state    <= HOLD;
            r_o        <= 8'd1 << w_head;
            r_hold_cnt <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (r_hold_cnt != 8'd0) begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
          end else begin
            r_count <= r_count + 8'd1;
            // Next queued code loads on the same edge so o never gaps.
            if (w_pop) begin
              r_o        <= 8'd1 << w_head;
              r_hold_cnt <= HOLD_LOAD;
            end else begin
              r_state <= IDLE;
              r_o     <= 8'd0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_o     <= 8'd0;
        end
      endcase
    end
  end

endmodule
